// File: rtl/sdc_reg_write_arb.sv
// sdc_reg_write_arb: two-requester arbiter that serialises masked 32-bit writes
// into ascending one-byte writes on a byte_en_reg port. Rev 1.0
`default_nettype none

module sdc_reg_write_arb #(
  parameter int PRIO_RR    = 1,
  parameter int TURNAROUND = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req0,
  input  logic [3:0]  i_mask0,
  input  logic [31:0] i_data0,
  output logic        o_ack0,
  input  logic        i_req1,
  input  logic [3:0]  i_mask1,
  input  logic [31:0] i_data1,
  output logic        o_ack1,
  output logic        o_we,
  output logic [1:0]  o_byte_sel,
  output logic [7:0]  o_byte_in,
  output logic        o_grant,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [2:0] C_GAP_LAST = (TURNAROUND == 0) ? 3'd0 : 3'(TURNAROUND - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_mask, w_mask_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_fav1, w_fav1_nxt;
  logic [2:0]  r_gap, w_gap_nxt;
  logic        r_we, w_we_nxt;
  logic [1:0]  r_sel, w_sel_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic        r_ack0, w_ack0_nxt;
  logic        r_ack1, w_ack1_nxt;
  logic        r_grant, w_grant_nxt;
  logic        r_busy, w_busy_nxt;

  logic        w_any, w_win, w_arb_slot;
  logic [3:0]  w_src_mask;
  logic [31:0] w_src_data;
  logic [1:0]  w_src_idx, w_rem_idx;

  function automatic logic [1:0] f_lsb(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // w_win = 1 selects requester 1; r_fav1 marks requester 1 as next in round-robin
  assign w_any      = i_req0 | i_req1;
  assign w_win      = (PRIO_RR != 0) ? (i_req1 & (~i_req0 | r_fav1)) : (i_req1 & ~i_req0);
  assign w_src_mask = w_win ? i_mask1 : i_mask0;
  assign w_src_data = w_win ? i_data1 : i_data0;
  assign w_src_idx  = f_lsb(w_src_mask);
  assign w_rem_idx  = f_lsb(r_mask);

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_data_nxt  = r_data;
    w_fav1_nxt  = r_fav1;
    w_gap_nxt   = r_gap;
    w_we_nxt    = 1'b0;
    w_sel_nxt   = r_sel;
    w_byte_nxt  = r_byte;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_arb_slot  = 1'b0;

    case (r_state)
      ST_IDLE: w_arb_slot = 1'b1;
      ST_WRITE: begin
        if (r_mask != 4'd0) begin
          w_we_nxt   = 1'b1;
          w_sel_nxt  = w_rem_idx;
          w_byte_nxt = r_data[{w_rem_idx, 3'b000} +: 8];
          w_mask_nxt = r_mask & ~(4'b0001 << w_rem_idx);
        end else begin
          w_state_nxt = ST_ACK;
          w_ack0_nxt  = ~r_grant;
          w_ack1_nxt  = r_grant;
        end
      end
      ST_ACK: begin
        if (TURNAROUND == 0) begin
          w_arb_slot = 1'b1;
        end else begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = 3'd0;
        end
      end
      ST_GAP: begin
        if (r_gap == C_GAP_LAST) w_arb_slot = 1'b1;
        else                     w_gap_nxt  = r_gap + 3'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // The edge that ends the idle/turnaround period is itself a grant opportunity,
    // and the first byte of a granted word is written on the grant edge.
    if (w_arb_slot) begin
      w_busy_nxt = w_any;
      if (w_any) begin
        w_grant_nxt = w_win;
        w_fav1_nxt  = ~w_win;
        w_data_nxt  = w_src_data;
        if (w_src_mask != 4'd0) begin
          w_state_nxt = ST_WRITE;
          w_we_nxt    = 1'b1;
          w_sel_nxt   = w_src_idx;
          w_byte_nxt  = w_src_data[{w_src_idx, 3'b000} +: 8];
          w_mask_nxt  = w_src_mask & ~(4'b0001 << w_src_idx);
        end else begin
          w_state_nxt = ST_ACK;
          w_mask_nxt  = 4'd0;
          w_ack0_nxt  = ~w_win;
          w_ack1_nxt  = w_win;
        end
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= 4'd0;
      r_data  <= 32'd0;
      r_fav1  <= 1'b0;
      r_gap   <= 3'd0;
      r_we    <= 1'b0;
      r_sel   <= 2'd0;
      r_byte  <= 8'd0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_grant <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_data  <= w_data_nxt;
      r_fav1  <= w_fav1_nxt;
      r_gap   <= w_gap_nxt;
      r_we    <= w_we_nxt;
      r_sel   <= w_sel_nxt;
      r_byte  <= w_byte_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_we       = r_we;
  assign o_byte_sel = r_sel;
  assign o_byte_in  = r_byte;
  assign o_ack0     = r_ack0;
  assign o_ack1     = r_ack1;
  assign o_grant    = r_grant;
  assign o_busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sdc_reg_write_arb.sv
// tb_sdc_reg_write_arb: directed bench for three parameterisations sharing one stimulus.
// Rev 1.0
`default_nettype none

module tb_sdc_reg_write_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [3:0]  mask0, mask1;
  logic [31:0] data0, data1;

  logic        we[3];
  logic [1:0]  sel[3];
  logic [7:0]  byt[3];
  logic        ack0[3], ack1[3], grant[3], busy[3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: round-robin, no gap; 1: fixed priority, no gap; 2: round-robin, 2-cycle gap
  sdc_reg_write_arb #(.PRIO_RR(1), .TURNAROUND(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_mask0(mask0), .i_data0(data0), .o_ack0(ack0[0]),
    .i_req1(req1), .i_mask1(mask1), .i_data1(data1), .o_ack1(ack1[0]),
    .o_we(we[0]), .o_byte_sel(sel[0]), .o_byte_in(byt[0]), .o_grant(grant[0]), .o_busy(busy[0])
  );

  sdc_reg_write_arb #(.PRIO_RR(0), .TURNAROUND(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_mask0(mask0), .i_data0(data0), .o_ack0(ack0[1]),
    .i_req1(req1), .i_mask1(mask1), .i_data1(data1), .o_ack1(ack1[1]),
    .o_we(we[1]), .o_byte_sel(sel[1]), .o_byte_in(byt[1]), .o_grant(grant[1]), .o_busy(busy[1])
  );

  sdc_reg_write_arb #(.PRIO_RR(1), .TURNAROUND(2)) u_ta (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_mask0(mask0), .i_data0(data0), .o_ack0(ack0[2]),
    .i_req1(req1), .i_mask1(mask1), .i_data1(data1), .o_ack1(ack1[2]),
    .o_we(we[2]), .o_byte_sel(sel[2]), .o_byte_in(byt[2]), .o_grant(grant[2]), .o_busy(busy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [14:0] outs(input int i);
    return {we[i], sel[i], byt[i], ack0[i], ack1[i], grant[i], busy[i]};
  endfunction

  task automatic chk_w(input string tag, input int i, input logic [1:0] s, input logic [7:0] b);
    chk(tag, {21'd0, we[i], sel[i], byt[i]}, {21'd0, 1'b1, s, b});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  full_b[4];
    logic [12:0] ta_tbl[15];
    logic        g;
    logic [3:0]  exp_rr, exp_fp;

    full_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ta_tbl = '{
      {3'b110, 2'd0, 8'hEF}, {3'b110, 2'd1, 8'hBE}, {3'b110, 2'd2, 8'hAD},
      {3'b110, 2'd3, 8'hDE}, {3'b101, 2'd3, 8'hDE}, {3'b100, 2'd3, 8'hDE},
      {3'b100, 2'd3, 8'hDE}, {3'b110, 2'd0, 8'h04}, {3'b110, 2'd1, 8'h03},
      {3'b110, 2'd2, 8'h02}, {3'b110, 2'd3, 8'h01}, {3'b101, 2'd3, 8'h01},
      {3'b100, 2'd3, 8'h01}, {3'b100, 2'd3, 8'h01}, {3'b000, 2'd3, 8'h01}
    };

    rst_n = 1'b0;
    req0 = 1'b0; mask0 = 4'd0; data0 = 32'd0;
    req1 = 1'b0; mask1 = 4'd0; data1 = 32'd0;
    tick_n(2);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_outs%0d", i), {17'd0, outs(i)}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full word on requester 0
    req0 = 1'b1; mask0 = 4'b1111; data0 = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_w($sformatf("full_w%0d", k), 0, k[1:0], full_b[k]);
    end
    tick();
    chk("full_ack", {28'd0, we[0], ack0[0], ack1[0], busy[0]}, {28'd0, 4'b0101});
    req0 = 1'b0;
    tick();
    chk("full_idle", {30'd0, busy[0], ack0[0]}, 32'd0);
    tick_n(3);

    // Sparse mask on requester 1
    req1 = 1'b1; mask1 = 4'b1010; data1 = 32'h11223344;
    tick();
    chk_w("sparse_w0", 0, 2'd1, 8'h33);
    chk("sparse_g0", {31'd0, grant[0]}, 32'd1);
    tick();
    chk_w("sparse_w1", 0, 2'd3, 8'h11);
    chk("sparse_g1", {31'd0, grant[0]}, 32'd1);
    tick();
    chk("sparse_ack", {28'd0, we[0], ack0[0], ack1[0], grant[0]}, {28'd0, 4'b0011});
    req1 = 1'b0;
    tick();
    chk("sparse_idle", {31'd0, busy[0]}, 32'd0);
    tick_n(2);

    // Empty mask
    req0 = 1'b1; mask0 = 4'b0000; data0 = 32'hCAFEF00D;
    tick();
    chk("empty_ack", {28'd0, we[0], ack0[0], ack1[0], busy[0]}, {28'd0, 4'b0101});
    req0 = 1'b0;
    tick();
    chk("empty_idle", {29'd0, we[0], ack0[0], busy[0]}, 32'd0);
    tick_n(2);

    // Contention, both held high with a single-lane mask
    do_reset();
    req0 = 1'b1; mask0 = 4'b0001; data0 = 32'h000000A0;
    req1 = 1'b1; mask1 = 4'b0001; data1 = 32'h000000B1;
    for (int k = 0; k < 8; k++) begin
      tick();
      g = ((k >> 1) & 1) != 0;
      exp_rr = (k % 2 == 0) ? {1'b1, 2'b00, g} : {1'b0, ~g, g, g};
      exp_fp = (k % 2 == 0) ? 4'b1000 : 4'b0100;
      chk($sformatf("rr_c%0d", k), {28'd0, we[0], ack0[0], ack1[0], grant[0]}, {28'd0, exp_rr});
      chk($sformatf("fp_c%0d", k), {28'd0, we[1], ack0[1], ack1[1], grant[1]}, {28'd0, exp_fp});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick_n(2);

    // Reset in the middle of a full-word write
    do_reset();
    req0 = 1'b1; mask0 = 4'b1111; data0 = 32'hDEADBEEF;
    tick();
    chk_w("rst_pre_w0", 0, 2'd0, 8'hEF);
    tick();
    chk_w("rst_pre_w1", 0, 2'd1, 8'hBE);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", {17'd0, outs(0)}, 32'd0);
    tick();
    chk("rst_held_clear", {17'd0, outs(0)}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_w($sformatf("rst_post_w%0d", k), 0, k[1:0], full_b[k]);
    end
    tick();
    chk("rst_post_ack", {30'd0, we[0], ack0[0]}, 32'd1);
    req0 = 1'b0;
    tick_n(2);

    // Turnaround of two cycles with a back-to-back request and data changed mid-write
    do_reset();
    req0 = 1'b1; mask0 = 4'b1111; data0 = 32'hDEADBEEF;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("ta_c%0d", k), {19'd0, busy[2], we[2], ack0[2], sel[2], byt[2]},
          {19'd0, ta_tbl[k]});
      chk($sformatf("ta_g%0d", k), {30'd0, grant[2], ack1[2]}, 32'd0);
      if (k == 0) data0 = 32'h01020304;
      if (k == 7) req0 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
